// File: rtl/stacker_pkg.sv
// Shared definitions for the block stacker: FSM and direction encodings,
// default playfield geometry and the video frame rate.
package stacker_pkg;

   localparam int ROW_W_DEF   = 8;
   localparam int SPEED_W_DEF = 6;
   localparam int FPS         = 60;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MOVE = 2'd1,
      ST_EVAL = 2'd2
   } state_e;

   typedef enum logic {
      DIR_RIGHT = 1'b0,
      DIR_LEFT  = 1'b1
   } dir_e;

endpackage

// File: rtl/frame_divider.sv
// Divides frame_tick down to one step every max(speed_count,1) frames.
// The counter holds at zero while clear is high.
module frame_divider
   import stacker_pkg::*;
#(
   parameter int SPEED_W = SPEED_W_DEF
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               frame_tick,
   input  logic [SPEED_W-1:0] speed_count,
   input  logic               clear,
   output logic               step
);

   logic [SPEED_W-1:0] cnt_q, cnt_d;
   logic [SPEED_W-1:0] limit;

   // >= rather than == so that lowering speed_count mid-row below the current
   // count steps at the next tick instead of running the counter round its range.
   always_comb begin
      limit = (speed_count == '0) ? '0 : speed_count - 1'b1;
      step  = frame_tick && !clear && (cnt_q >= limit);
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (frame_tick) begin
         cnt_d = step ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/row_slider.sv
// Moving-row engine: sweeps a row of blocks back and forth and scores drops
// against the stack. Define ROW_SLIDER_TRIM_EN to size/place rows from the stack.
module row_slider
   import stacker_pkg::*;
#(
   parameter int ROW_W   = ROW_W_DEF,
   parameter int SPEED_W = SPEED_W_DEF,
   parameter int NB_W    = 4
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               frame_tick,
   input  logic               go,
   input  logic               drop,
   input  logic [SPEED_W-1:0] speed_count,
   input  logic [NB_W-1:0]    num_blocks,
   output logic [ROW_W-1:0]   row_out,
   output logic [ROW_W-1:0]   stack_row,
   output logic               busy,
   output logic               next_signal,
   output logic               fail,
   output logic [3:0]         row_index
);

   state_e             state_q, state_d;
   dir_e               dir_q, dir_d;
   logic [ROW_W-1:0]   row_q, row_d;
   logic [ROW_W-1:0]   stack_q, stack_d;
   logic [3:0]         idx_q, idx_d;
   logic               next_q, next_d;
   logic               fail_q, fail_d;
   logic [ROW_W-1:0]   ov;
   logic               step;
   int                 w;
   int                 pos;

   frame_divider #(.SPEED_W(SPEED_W)) u_div (
      .clk         (clk),
      .resetn      (resetn),
      .frame_tick  (frame_tick),
      .speed_count (speed_count),
      .clear       (state_q != ST_MOVE),
      .step        (step)
   );

   function automatic logic [ROW_W-1:0] load_mask(input int width, input int lsb);
      logic [ROW_W-1:0] m;
      for (int i = 0; i < ROW_W; i++) begin
         m[i] = (i >= lsb) && (i < lsb + width);
      end
      return m;
   endfunction

`ifdef ROW_SLIDER_TRIM_EN
   function automatic int popcount(input logic [ROW_W-1:0] v);
      int c;
      c = 0;
      for (int i = 0; i < ROW_W; i++) begin
         c += int'(v[i]);
      end
      return c;
   endfunction

   function automatic int lowest_set(input logic [ROW_W-1:0] v);
      int p;
      p = 0;
      for (int i = ROW_W - 1; i >= 0; i--) begin
         if (v[i]) p = i;
      end
      return p;
   endfunction
`endif

   always_comb begin
`ifdef ROW_SLIDER_TRIM_EN
      w   = (int'(num_blocks) < popcount(stack_q)) ? int'(num_blocks) : popcount(stack_q);
      pos = lowest_set(stack_q);
`else
      w   = int'(num_blocks);
      pos = 0;
`endif
      if (w > ROW_W) w = ROW_W;
      if (w == 0)    w = 1;
   end

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      row_d   = row_q;
      stack_d = stack_q;
      idx_d   = idx_q;
      next_d  = 1'b0;
      fail_d  = 1'b0;
      ov      = row_q & stack_q;
      case (state_q)
         ST_IDLE: begin
            if (go) begin
               row_d   = load_mask(w, pos);
               dir_d   = DIR_RIGHT;
               state_d = ST_MOVE;
            end
         end
         ST_MOVE: begin
            // A full-width row has nowhere to go, so it never shifts or bounces.
            if (drop) begin
               state_d = ST_EVAL;
            end else if (step && (row_q != '1)) begin
               if (dir_q == DIR_RIGHT) begin
                  if (!row_q[ROW_W-1]) begin
                     row_d = row_q << 1;
                  end else begin
                     dir_d = DIR_LEFT;
                     row_d = row_q >> 1;
                  end
               end else begin
                  if (!row_q[0]) begin
                     row_d = row_q >> 1;
                  end else begin
                     dir_d = DIR_RIGHT;
                     row_d = row_q << 1;
                  end
               end
            end
         end
         ST_EVAL: begin
            if (ov != '0) begin
               stack_d = ov;
               row_d   = ov;
               next_d  = 1'b1;
               idx_d   = idx_q + 4'd1;
            end else begin
               stack_d = '1;
               row_d   = '0;
               fail_d  = 1'b1;
               idx_d   = 4'd0;
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         dir_q   <= DIR_RIGHT;
         row_q   <= '0;
         stack_q <= '1;
         idx_q   <= 4'd0;
         next_q  <= 1'b0;
         fail_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         row_q   <= row_d;
         stack_q <= stack_d;
         idx_q   <= idx_d;
         next_q  <= next_d;
         fail_q  <= fail_d;
      end
   end

   assign row_out     = row_q;
   assign stack_row   = stack_q;
   assign busy        = (state_q != ST_IDLE);
   assign next_signal = next_q;
   assign fail        = fail_q;
   assign row_index   = idx_q;

endmodule
